axi4_lite_wr_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4-Lite write-master user interface (wr_addr/wr_data/wr_valid/wr_ready) among NUM_REQ independent requesters.
- Latches the winning request, holds it stable for the whole downstream transaction, returns a one-cycle completion to the winner, then re-arbitrates.
- Includes a watchdog that flags transactions stuck longer than TIMEOUT_CYCLES.
- Sits between configuration/control clients and the AXI4-Lite write master.

---
 rtl/axi4_lite_wr_arbiter_if.sv | 30 +++
 rtl/axi4_lite_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_axi4_lite_wr_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_wr_arbiter_if.sv
// Bundle between NUM_REQ requesters, the round-robin write arbiter and the AXI4-Lite write master.
// Handshake: a requester holds req_valid/addr/data stable until its one-cycle req_ready pulse; wr_valid stays high until a one-cycle wr_ready.
interface axi4_lite_wr_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           wr_addr;
    logic [31:0]           wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  busy;
    logic [GW-1:0]         grant_id;
    logic                  timeout_err;
    logic [1:0]            dbg_state;

    modport slave (
        input  req_valid, req_addr, req_data, wr_ready,
        output req_ready, wr_addr, wr_data, wr_valid, busy, grant_id, timeout_err, dbg_state
    );

    modport master (
        output req_valid, req_addr, req_data, wr_ready,
        input  req_ready, wr_addr, wr_data, wr_valid, busy, grant_id, timeout_err, dbg_state
    );
endinterface

// File: rtl/axi4_lite_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite write-master port among NUM_REQ requesters,
// with a watchdog that flags a write stuck in BUSY for TIMEOUT_CYCLES cycles.
module axi4_lite_wr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  arst_n,
    axi4_lite_wr_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_wr_addr;
    logic [31:0]          r_wr_data;
    logic                 r_wr_valid;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic                 r_busy;
    logic [GW-1:0]        r_grant;
    logic                 r_timeout;
    logic [CW-1:0]        r_wd_cnt;

    logic                 w_found;
    logic [GW-1:0]        w_idx;
    logic [GW-1:0]        w_next;
    logic [31:0]          w_next_addr;
    logic [31:0]          w_next_data;

    // Scan starts one past the last grant so the most recent winner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_grant;
        w_next  = r_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((int'(r_grant) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    always_comb begin
        w_next_addr = '0;
        w_next_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_next == GW'(i)) begin
                w_next_addr = bus.req_addr[32*i +: 32];
                w_next_data = bus.req_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= ST_IDLE;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_valid  <= 1'b0;
            r_req_ready <= '0;
            r_busy      <= 1'b0;
            r_grant     <= GW'(NUM_REQ - 1);
            r_timeout   <= 1'b0;
            r_wd_cnt    <= '0;
        end else begin
            r_req_ready <= '0;
            r_timeout   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_next;
                        r_wr_addr  <= w_next_addr;
                        r_wr_data  <= w_next_data;
                        r_wr_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_wd_cnt   <= '0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.wr_ready) begin
                        r_wr_valid  <= 1'b0;
                        r_req_ready <= ONE_HOT0 << r_grant;
                        r_wd_cnt    <= '0;
                        r_state     <= ST_ACK;
                    end else if (WD_EN) begin
                        // Counting on to TO_MAX and parking there keeps the pulse to one per transaction.
                        if (r_wd_cnt != TO_MAX) begin
                            r_wd_cnt <= r_wd_cnt + 1'b1;
                        end
                        r_timeout <= (r_wd_cnt == TO_LAST);
                    end
                end
                ST_ACK: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_wr_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.wr_valid    = r_wr_valid;
    assign bus.req_ready   = r_req_ready;
    assign bus.busy        = r_busy;
    assign bus.grant_id    = r_grant;
    assign bus.timeout_err = r_timeout;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_axi4_lite_wr_arbiter.sv
// Directed bench for axi4_lite_wr_arbiter: latency, round-robin order, watchdog, async reset, spurious wr_ready.
module tb_axi4_lite_wr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TO      = 8;

    logic clk = 1'b0;
    logic arst_n;

    always #5 clk = ~clk;

    axi4_lite_wr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    axi4_lite_wr_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] addr_tab[NUM_REQ];
    logic [31:0] data_tab[NUM_REQ];
    int          ack_cnt[NUM_REQ];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n        = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.wr_ready  = 1'b0;
        tick();
        tick();
        arst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d);
        addr_tab[i] = a;
        data_tab[i] = d;
        bus.req_addr[32*i +: 32] = a;
        bus.req_data[32*i +: 32] = d;
        bus.req_valid[i] = 1'b1;
    endtask

    // Counts low samples of wr_valid before it rises; from an ACK sample this is the gap.
    task automatic wait_wvalid(output int n);
        n = 0;
        while (bus.wr_valid !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        if (n >= 50) check("wr_valid_wait_expired", 64'd0, 64'd1);
    endtask

    // Entered on the first BUSY sample; leaves on the ACK sample.
    task automatic complete_txn(input string t, input int e, input int delay);
        logic [NUM_REQ-1:0] oh;
        oh    = '0;
        oh[e] = 1'b1;
        check({t, "_grant"}, bus.grant_id, e);
        check({t, "_addr"}, bus.wr_addr, addr_tab[e]);
        check({t, "_data"}, bus.wr_data, data_tab[e]);
        repeat (delay) tick();
        bus.wr_ready = 1'b1;
        tick();
        bus.wr_ready = 1'b0;
        check({t, "_req_ready"}, bus.req_ready, oh);
        check({t, "_wvalid_ack"}, bus.wr_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int e;
        int pulses;
        int pulse_at;

        // Reset state
        do_reset();
        check("rst_wvalid", bus.wr_valid, 1'b0);
        check("rst_waddr", bus.wr_addr, 32'h0);
        check("rst_wdata", bus.wr_data, 32'h0);
        check("rst_req_ready", bus.req_ready, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_timeout", bus.timeout_err, 1'b0);
        check("rst_grant", bus.grant_id, 2'd3);
        check("rst_state", bus.dbg_state, 2'd0);

        // 1: single request from requester 2, wr_ready 5 cycles after wr_valid
        set_req(2, 32'h0000_0010, 32'hDEAD_BEEF);
        check("t1_wvalid_pre", bus.wr_valid, 1'b0);
        tick();
        check("t1_wvalid_lat", bus.wr_valid, 1'b1);
        check("t1_busy", bus.busy, 1'b1);
        check("t1_grant", bus.grant_id, 2'd2);
        check("t1_addr_data", {bus.wr_addr, bus.wr_data}, {32'h0000_0010, 32'hDEAD_BEEF});
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t1_hold", {bus.wr_addr, bus.wr_data}, {32'h0000_0010, 32'hDEAD_BEEF});
            check("t1_hold_wvalid", bus.wr_valid, 1'b1);
        end
        tick();
        bus.wr_ready = 1'b1;
        tick();
        bus.wr_ready = 1'b0;
        check("t1_req_ready", bus.req_ready, 4'b0100);
        check("t1_wvalid_ack", bus.wr_valid, 1'b0);
        bus.req_valid[2] = 1'b0;
        tick();
        check("t1_req_ready_pulse", bus.req_ready, 4'b0000);
        check("t1_busy_idle", bus.busy, 1'b0);
        check("t1_addr_kept", bus.wr_addr, 32'h0000_0010);

        // 2: all four continuously, grant order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 32'(4 * i), 32'hA000_0000 + 32'(i));
            ack_cnt[i] = 0;
        end
        exp_q = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd0};
        wait_wvalid(n);
        for (int t = 0; t < 5; t++) begin
            e = int'(exp_q.pop_front());
            if (t > 0) check("t2_gap", n, 2);
            complete_txn("t2", e, 1);
            for (int j = 0; j < NUM_REQ; j++) ack_cnt[j] += int'(bus.req_ready[j]);
            if (t == 3) begin
                for (int j = 0; j < NUM_REQ; j++) check("t2_one_ack_per_round", ack_cnt[j], 1);
            end
            if (t < 4) wait_wvalid(n);
        end
        bus.req_valid = '0;
        tick();
        tick();

        // 3: after grant 2, requesters 1 and 3 -> 3,1,3
        do_reset();
        set_req(2, 32'h0000_0200, 32'h2222_2222);
        wait_wvalid(n);
        complete_txn("t3_setup", 2, 0);
        bus.req_valid[2] = 1'b0;
        set_req(1, 32'h0000_0100, 32'h1111_1111);
        set_req(3, 32'h0000_0300, 32'h3333_3333);
        exp_q = '{64'd3, 64'd1, 64'd3};
        for (int t = 0; t < 3; t++) begin
            wait_wvalid(n);
            check("t3_gap", n, 2);
            e = int'(exp_q.pop_front());
            complete_txn("t3", e, 0);
        end
        bus.req_valid = '0;
        tick();
        tick();

        // 4: watchdog, wr_ready withheld 20 cycles
        do_reset();
        set_req(0, 32'h0000_0040, 32'h0000_0044);
        wait_wvalid(n);
        pulses   = 0;
        pulse_at = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.timeout_err === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
            tick();
        end
        check("t4_pulse_count", pulses, 1);
        check("t4_pulse_cycle", pulse_at, 8);
        check("t4_still_busy", bus.wr_valid, 1'b1);
        bus.wr_ready = 1'b1;
        tick();
        bus.wr_ready = 1'b0;
        check("t4_req_ready", bus.req_ready, 4'b0001);
        check("t4_no_second_pulse", bus.timeout_err, 1'b0);
        bus.req_valid = '0;
        tick();
        tick();

        // 5: async reset in the middle of BUSY
        set_req(2, 32'h0000_0500, 32'h5555_5555);
        wait_wvalid(n);
        tick();
        #2;
        arst_n = 1'b0;
        #1;
        check("t5_async_wvalid", bus.wr_valid, 1'b0);
        check("t5_async_busy", bus.busy, 1'b0);
        check("t5_async_req_ready", bus.req_ready, 4'b0000);
        check("t5_async_grant", bus.grant_id, 2'd3);
        tick();
        arst_n = 1'b1;
        bus.req_valid = '0;
        set_req(0, 32'h0000_0600, 32'h6666_6666);
        set_req(1, 32'h0000_0700, 32'h7777_7777);
        check("t5_no_ack_after_rst", bus.req_ready, 4'b0000);
        wait_wvalid(n);
        complete_txn("t5_first", 0, 0);
        bus.req_valid[0] = 1'b0;
        wait_wvalid(n);
        complete_txn("t5_second", 1, 0);
        bus.req_valid = '0;
        tick();
        tick();

        // 6: spurious wr_ready while idle
        bus.wr_ready = 1'b1;
        tick();
        bus.wr_ready = 1'b0;
        check("t6_req_ready", bus.req_ready, 4'b0000);
        check("t6_busy", bus.busy, 1'b0);
        check("t6_state", bus.dbg_state, 2'd0);
        check("t6_wvalid", bus.wr_valid, 1'b0);
        tick();
        check("t6_req_ready_after", bus.req_ready, 4'b0000);
        check("t6_busy_after", bus.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
